// File: rtl/clk_rst_seq.sv
// clk_rst_seq: staged per-channel reset release with per-channel clock-enable dividers
// Ports: clk_sys_i system clock; rst_i async active-high reset; en_i divider run enable;
//        soft_rst_i sync sequence restart; div_i per-channel divide words;
//        clk_en_o per-channel strobe; clk_div_o per-channel divided clock;
//        rstn_o per-channel active-low reset; done_o all channels released.
module clk_rst_seq #(
  parameter int G_NUM_CH      = 4,
  parameter int G_DIV_WIDTH   = 16,
  parameter int G_RST_DELAY   = 16,
  parameter int G_RST_STAGGER = 8
) (
  input  logic                            clk_sys_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic                            soft_rst_i,
  input  logic [G_NUM_CH*G_DIV_WIDTH-1:0] div_i,
  output logic [G_NUM_CH-1:0]             clk_en_o,
  output logic [G_NUM_CH-1:0]             clk_div_o,
  output logic [G_NUM_CH-1:0]             rstn_o,
  output logic                            done_o
);
  localparam int LAST = G_RST_DELAY + (G_NUM_CH - 1) * G_RST_STAGGER;
  localparam int CW   = $clog2(LAST + 1);
  typedef enum logic [1:0] {HOLD, STAGGER, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] seq_cnt_q, seq_cnt_d;
  logic [G_NUM_CH-1:0] rstn_q, rstn_d, clk_en_q, clk_en_d, clk_div_q, clk_div_d;
  logic [G_NUM_CH-1:0] act, rel, hit;
  logic done_q, done_d;
  logic [G_NUM_CH-1:0][G_DIV_WIDTH-1:0] cnt_q, cnt_d, dv_q, dv_d;
  always_comb begin
    // seq_cnt equals the number of edges since sequence start until RUN freezes it
    seq_cnt_d = (state_q == RUN) ? seq_cnt_q : seq_cnt_q + CW'(1);
    // channel k releases on the edge leaving seq_cnt at its release number
    for (int k = 0; k < G_NUM_CH; k++)
      rstn_d[k] = rstn_q[k] | (32'(seq_cnt_q) == G_RST_DELAY - 1 + k * G_RST_STAGGER);
    done_d = &rstn_d;
    state_d = done_d ? RUN : (32'(seq_cnt_d) >= G_RST_DELAY - 1) ? STAGGER : HOLD;
    act = rstn_q & {G_NUM_CH{en_i}};
    rel = rstn_d & ~rstn_q;
    for (int k = 0; k < G_NUM_CH; k++) begin
      hit[k] = act[k] & (cnt_q[k] == dv_q[k]);
      cnt_d[k] = hit[k] ? '0 : act[k] ? cnt_q[k] + G_DIV_WIDTH'(1) : cnt_q[k];
      // divide word is sampled only at release and at each period boundary
      dv_d[k] = (hit[k] | rel[k]) ? div_i[k*G_DIV_WIDTH +: G_DIV_WIDTH] : dv_q[k];
    end
    clk_en_d  = hit;
    clk_div_d = clk_div_q ^ hit;
    if (soft_rst_i) begin
      state_d   = HOLD;
      seq_cnt_d = '0;
      rstn_d    = '0;
      done_d    = 1'b0;
      cnt_d     = '0;
      dv_d      = '0;
      clk_en_d  = '0;
      clk_div_d = '0;
    end
  end
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= HOLD;
      seq_cnt_q <= '0;
      rstn_q    <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      dv_q      <= '0;
      clk_en_q  <= '0;
      clk_div_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      rstn_q    <= rstn_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      dv_q      <= dv_d;
      clk_en_q  <= clk_en_d;
      clk_div_q <= clk_div_d;
    end
  end
  assign clk_en_o  = clk_en_q;
  assign clk_div_o = clk_div_q;
  assign rstn_o    = rstn_q;
  assign done_o    = done_q;
endmodule
